// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-beat local commands into AXI4-Lite write or read
// transactions. Only one transaction is in flight at a time. A saturating counter
// raises a sticky timeout flag when a transaction stalls for too long.
//
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   cmd_*                   local command channel (valid/ready, write, addr, wdata, wstrb, prot)
//   rsp_*                   local response channel (valid/ready, write echo, rdata, resp)
//   timeout_flag            sticky hang indicator, cleared on command acceptance
//   aw*/w*/b*/ar*/r*        AXI4-Lite master interface
//
// DATA_WIDTH must be 32 or 64. TIMEOUT_CYCLES = 0 disables the hang counter.
module axi4_lite_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // Local command / response
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout_flag,
    // AXI write address
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    // AXI write response
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // AXI read address
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    // AXI read data
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StRsp
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [2:0]              prot_q, prot_d;
    logic                    write_q, write_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    flag_q, flag_d;
    logic                    busy;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        write_d     = write_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // cmd_ready_q is only ever high in StIdle
                if (cmd_valid && cmd_ready_q) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    prot_d    = cmd_prot;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                    flag_d    = 1'b0;
                    state_d   = cmd_write ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                busy      = 1'b1;
                // Each valid stays up until its own handshake, independently of the other
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                busy   = 1'b1;
                bready = 1'b1;
                if (bvalid) begin
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                    state_d     = StRsp;
                end
            end
            StRdReq: begin
                busy    = 1'b1;
                arvalid = 1'b1;
                if (arready) begin
                    state_d = StRdData;
                end
            end
            StRdData: begin
                busy   = 1'b1;
                rready = 1'b1;
                if (rvalid) begin
                    rsp_resp_d  = rresp;
                    rsp_rdata_d = rdata;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Hang counter saturates at CNT_MAX; the transaction itself carries on.
        if (TIMEOUT_CYCLES != 0 && busy && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_d == CNT_MAX) begin
                flag_d = 1'b1;
            end
        end

        // Registered so cmd_ready stays low during reset and rises the cycle after
        // the response handshake.
        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            write_q     <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            write_q     <= write_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_write    = write_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_resp     = rsp_resp_q;
    assign timeout_flag = flag_q;
    assign awaddr       = addr_q;
    assign araddr       = addr_q;
    assign awprot       = prot_q;
    assign arprot       = prot_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;

endmodule
